// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths, indices and word types
package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;
  localparam int ZERO_REG   = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_row.sv
// rtl/regfile_row.sv - one register row: async active-low clear, posedge capture with load enable
module regfile_row #(
  parameter int DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 2-read/1-write register file, reg 0 hardwired to zero
// Optional write-through forwarding: REGFILE_BYPASS_EN
module reg_file_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [DATA_W-1:0] RdDataA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [DATA_W-1:0] RdDataB,
  output logic              WrZeroErr
);

  localparam int                NUM_ROWS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [NUM_ROWS];

  // Row 0 has no storage; every other row loads only on its own index.
  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_row
      regfile_row #(
        .DATA_W (DATA_W)
      ) u_row (
        .Clock (Clock),
        .Reset (Reset),
        .load  (WrEn && (WrAddr == ADDR_W'(i))),
        .d     (WrData),
        .q     (mem[i])
      );
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      WrZeroErr <= 1'b0;
    end else if (WrEn && (WrAddr == ZERO_IDX)) begin
      WrZeroErr <= 1'b1;
    end
  end

  logic [DATA_W-1:0] stored_a;
  logic [DATA_W-1:0] stored_b;

  always_comb begin
    stored_a = '0;
    stored_b = '0;
    if (RdAddrA != ZERO_IDX) stored_a = mem[RdAddrA];
    if (RdAddrB != ZERO_IDX) stored_b = mem[RdAddrB];
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is gated by Reset so a held write cannot leak out during reset.
  logic wr_live;
  assign wr_live = Reset && WrEn && (WrAddr != ZERO_IDX);
  assign RdDataA = (wr_live && (RdAddrA == WrAddr)) ? WrData : stored_a;
  assign RdDataB = (wr_live && (RdAddrB == WrAddr)) ? WrData : stored_b;
`else
  assign RdDataA = stored_a;
  assign RdDataB = stored_b;
`endif

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - self-checking bench for reg_file_2r1w (honours REGFILE_BYPASS_EN)
module tb_reg_file_2r1w;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        WrEn;
  logic [2:0]  WrAddr;
  logic [15:0] WrData;
  logic [2:0]  RdAddrA;
  logic [15:0] RdDataA;
  logic [2:0]  RdAddrB;
  logic [15:0] RdDataB;
  logic        WrZeroErr;

  reg_file_2r1w dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .RdAddrA   (RdAddrA),
    .RdDataA   (RdDataA),
    .RdAddrB   (RdAddrB),
    .RdDataB   (RdDataB),
    .WrZeroErr (WrZeroErr)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  logic [15:0] model [8];
  logic        model_err;

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        eerr;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [2:0] ra, input logic [2:0] rb);
    WrEn    = we;
    WrAddr  = wa;
    WrData  = wd;
    RdAddrA = ra;
    RdAddrB = rb;
  endtask

  // One clock: the model applies the write rules at the edge, then we settle on the negedge.
  task automatic tick();
    @(posedge Clock);
    if (Reset && WrEn) begin
      if (WrAddr != 3'd0) model[WrAddr] = WrData;
      else model_err = 1'b1;
    end
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #2;
    Reset = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    model_err = 1'b0;
  endtask

  function automatic logic [15:0] exp_rd(input logic [2:0] addr);
    if (addr == 3'd0) return 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (Reset && WrEn && WrAddr != 3'd0 && addr == WrAddr) return WrData;
`endif
    return model[addr];
  endfunction

  initial begin
    tbl[0] = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 1'b0};
    tbl[1] = '{1'b1, 3'd3, 16'h1234, 3'd3, 3'd5, 16'h1234, 16'hBEEF, 1'b0};
    tbl[2] = '{1'b0, 3'd7, 16'hAAAA, 3'd7, 3'd3, 16'h0000, 16'h1234, 1'b0};
    tbl[3] = '{1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd5, 16'h0000, 16'hBEEF, 1'b1};
    tbl[4] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd3, 16'h0000, 16'h1234, 1'b1};
    tbl[5] = '{1'b1, 3'd5, 16'h0042, 3'd5, 3'd0, 16'h0042, 16'h0000, 1'b1};

    Reset = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    model_err = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 16'h0;
    #2;
    chk("reset_err", {15'b0, WrZeroErr}, 16'h0);
    chk("reset_rda", RdDataA, 16'h0);
    @(negedge Clock);
    Reset = 1'b1;

    // Table vectors, checked after each edge.
    foreach (tbl[k]) begin
      drive(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].ra, tbl[k].rb);
      tick();
      chk($sformatf("tbl%0d_a", k), RdDataA, tbl[k].ea);
      chk($sformatf("tbl%0d_b", k), RdDataB, tbl[k].eb);
      chk($sformatf("tbl%0d_err", k), {15'b0, WrZeroErr}, {15'b0, tbl[k].eerr});
    end

    // Async reset between edges clears storage and the sticky flag without a clock.
    drive(1'b1, 3'd3, 16'h1234, 3'd3, 3'd3);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_clr_a", RdDataA, 16'h0);
    chk("async_clr_err", {15'b0, WrZeroErr}, 16'h0);
    // A write held across an edge while in reset must be ignored and never forwarded.
    drive(1'b1, 3'd4, 16'h5A5A, 3'd4, 3'd4);
    #1;
    chk("rst_nofwd_a", RdDataA, 16'h0);
    @(posedge Clock);
    #1;
    chk("rst_nowrite_b", RdDataB, 16'h0);
    @(negedge Clock);
    drive(1'b0, 3'd0, 16'h0, 3'd4, 3'd4);
    do_reset();
    #1;
    chk("rst_release_a", RdDataA, 16'h0);

    // Same-cycle read/write of reg 2.
    drive(1'b1, 3'd2, 16'h1111, 3'd0, 3'd2);
    tick();
    drive(1'b1, 3'd2, 16'h2222, 3'd0, 3'd2);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rw_same_pre", RdDataB, 16'h2222);
`else
    chk("rw_same_pre", RdDataB, 16'h1111);
`endif
    tick();
    chk("rw_same_post", RdDataB, 16'h2222);

    // Write enable low over 4 clocks leaves reg 7 at zero.
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 3'd7, 16'hAAAA, 3'd7, 3'd7);
      tick();
      chk($sformatf("gate_c%0d", c), RdDataA, 16'h0);
    end

    // Sticky error survives later writes and reads, clears only on reset.
    drive(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0);
    tick();
    chk("zero_rd", RdDataA, 16'h0);
    chk("zero_err_set", {15'b0, WrZeroErr}, 16'h1);
    drive(1'b1, 3'd1, 16'h0001, 3'd1, 3'd0);
    tick();
    chk("zero_err_hold", {15'b0, WrZeroErr}, 16'h1);
    do_reset();
    #1;
    chk("zero_err_clr", {15'b0, WrZeroErr}, 16'h0);

    // Full sweep.
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 3'(i), 16'h0100 + 16'(i), 3'd0, 3'd0);
      tick();
    end
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0);
    for (int i = 0; i < 8; i++) begin
      RdAddrA = 3'(i);
      RdAddrB = 3'(8 - i);
      #1;
      chk($sformatf("sweep_a%0d", i), RdDataA, (i == 0) ? 16'h0 : 16'h0100 + 16'(i));
      chk($sformatf("sweep_b%0d", i), RdDataB, (i == 0) ? 16'h0 : 16'h0100 + 16'(8 - i));
    end
    @(negedge Clock);

    // Randomized traffic against the model, reads checked before each edge.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom),
            3'($urandom), 3'($urandom));
      #1;
      chk("rand_a", RdDataA, exp_rd(RdAddrA));
      chk("rand_b", RdDataB, exp_rd(RdAddrB));
      tick();
      chk("rand_err", {15'b0, WrZeroErr}, {15'b0, model_err});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
